ifetch_buffer: RTL and testbench
================================

Name: ifetch_buffer

Overview:
- Instruction fetch stage that sits directly upstream of the single-cycle cpu core.
- Takes the core's PC and returns the instruction word from a two-entry tagged buffer.
- On a miss, fetches the word from instruction memory over a req/ready + rvalid bus, and optionally prefetches PC+4.
- instr_valid_o is the core's advance enable; the integrating top gates the core update with it.

Parameters:
- PREFETCH_EN, 1, when 1, idle cycles are used to fetch PC+4 into the buffer.
- NOP_INSTR, 32'h00000013, instruction driven on instr_o while no valid word is available (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- pc_i  in  32  current core PC; bits [1:0] are ignored.
- flush_i  in  1  invalidates both entries and discards any in-flight response.
- instr_o  out  32  instruction for pc_i when instr_valid_o=1, else NOP_INSTR.
- instr_valid_o  out  1  combinational hit indication for pc_i.
- mem_req_o  out  1  request valid toward instruction memory.
- mem_addr_o  out  32  word-aligned request address, held stable while mem_req_o=1.
- mem_ready_i  in  1  memory accepts the request in a cycle where mem_req_o and mem_ready_i are both 1.
- mem_rvalid_i  in  1  response valid; at most one response per accepted request.
- mem_rdata_i  in  32  response data.
- fetch_count_o  out  32  number of accepted memory requests; wraps at 2^32.

Behaviour:
- Storage: entries E0 and E1, each {valid, tag[31:2], data[31:0]}, plus one lru bit pointing at the least-recently-hit entry.
- Hit: an entry with valid=1 and tag==pc_i[31:2] → instr_valid_o=1, instr_o=that entry's data, same cycle (combinational). A hit sets lru to the other entry.
- Miss: instr_valid_o=0, instr_o=NOP_INSTR.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If pc_i misses: latch mem_addr={pc_i[31:2],2'b00}, set kind=DEMAND, go to REQ.
  - Else if PREFETCH_EN and no valid entry has tag pc_i[31:2]+1: latch PC+4 word address (wraps mod 2^32), set kind=PREFETCH, go to REQ.
  - Otherwise stay in IDLE.
- REQ: mem_req_o=1 (registered, state-decoded). On mem_ready_i: fetch_count_o+1, go to WAIT. mem_addr_o must not change while in REQ.
- WAIT: on mem_rvalid_i, write the latched address and mem_rdata_i into the victim entry with valid=1, then go to IDLE. The write is visible as a hit in the next cycle.
- Victim selection:
  - If exactly one entry matches the current pc_i word, the victim is the other entry; this protects the executing word from a prefetch fill.
  - Otherwise the victim is the entry pointed to by lru.
- Stale responses: pc_i may change at any time. An in-flight response is still written, tagged with its own address; a request is never cancelled.
- mem_rvalid_i is ignored outside WAIT.
- flush_i:
  - In any state, clears both valid bits at the clock edge.
  - In WAIT, sets a drop flag; the pending response is consumed without a write, then FSM returns to IDLE.
  - In REQ, the request completes and its response is dropped.
  - flush_i has priority over a same-cycle fill.
- Miss latency with single-cycle memory (mem_ready_i=1, rvalid one cycle after acceptance):
  - pc miss seen at cycle t, mem_req_o=1 at t+1, rvalid at t+2, instr_valid_o=1 at t+3.
- Reset (synchronous, in any state, including mid-request): state=IDLE, E0.valid=E1.valid=0, lru=0, drop=0, mem_req_o=0, mem_addr_o=0, fetch_count_o=0, instr_valid_o=0, instr_o=NOP_INSTR.
  - A response arriving after reset is ignored because the FSM is in IDLE.
- Only one request is outstanding at any time.

Test Plan:
- Reset, pc_i=0x00400000, single-cycle memory returning 0x00500093 → mem_addr_o=0x00400000 at t+1; instr_valid_o=1 and instr_o=0x00500093 at t+3; fetch_count_o=1.
- Hold pc_i=0x00400000, PREFETCH_EN=1 → second request to 0x00400004 fills the other entry. Step pc_i to 0x00400004 → hit in the same cycle with no new demand miss; fetch_count_o=2, then a prefetch to 0x00400008 issues.
- mem_ready_i held 0 for 5 cycles while pc_i changes 0x00400000→0x00400100 → mem_addr_o stays 0x00400000. After completion, entry tag 0x00400000 is filled, then a demand request for 0x00400100 issues.
- flush_i pulsed during WAIT, response 0xDEADBEEF arrives → no entry written, instr_valid_o=0, new demand request issued for current pc_i.
- rst asserted while in WAIT, rvalid arrives the cycle after reset → ignored; all outputs at reset values; fetch_count_o=0.
- pc_i=0xFFFFFFFC with PREFETCH_EN=1 → prefetch address wraps to 0x00000000; pc_i=0x00400002 hits entry tagged 0x00400000.

Source files
------------

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: fetch stage feeding the single-cycle core from a
// two-entry tagged word buffer, refilled over a req/ready + rvalid bus.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_i                core PC (bits [1:0] ignored)
//   flush_i             invalidate entries, drop any in-flight response
//   instr_o             hit word, else NOP_INSTR
//   instr_valid_o       combinational hit for pc_i (core advance enable)
//   mem_req_o           request valid toward instruction memory
//   mem_addr_o          word-aligned request address
//   mem_ready_i         request accepted when high with mem_req_o
//   mem_rvalid_i        response valid
//   mem_rdata_i         response data
//   fetch_count_o       number of accepted requests
module ifetch_buffer #(
  parameter logic        PREFETCH_EN = 1'b1,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t      r_state;
  logic        r_v0;
  logic        r_v1;
  logic [29:0] r_tag0;
  logic [29:0] r_tag1;
  logic [31:0] r_data0;
  logic [31:0] r_data1;
  logic        r_lru;
  logic        r_drop;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_cnt;

  logic [29:0] w_tag;
  logic [29:0] w_ntag;
  logic        w_hit0;
  logic        w_hit1;
  logic        w_hit;
  logic        w_nhit;
  logic        w_vict;
  logic        w_unused;

  assign w_tag    = pc_i[31:2];
  assign w_ntag   = w_tag + 30'd1;
  assign w_unused = ^pc_i[1:0];

  assign w_hit0 = r_v0 && (r_tag0 == w_tag);
  assign w_hit1 = r_v1 && (r_tag1 == w_tag);
  assign w_hit  = w_hit0 || w_hit1;

  assign w_nhit = (r_v0 && (r_tag0 == w_ntag)) ||
                  (r_v1 && (r_tag1 == w_ntag));

  // Never overwrite the word the core is executing from;
  // fall back to lru when neither or both entries match.
  assign w_vict = (w_hit0 ^ w_hit1) ? w_hit0 : r_lru;

  assign instr_valid_o = w_hit;
  assign instr_o       = w_hit0 ? r_data0 :
                         w_hit1 ? r_data1 : NOP_INSTR;
  assign mem_req_o     = r_req;
  assign mem_addr_o    = r_addr;
  assign fetch_count_o = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_v0    <= 1'b0;
      r_v1    <= 1'b0;
      r_tag0  <= '0;
      r_tag1  <= '0;
      r_data0 <= '0;
      r_data1 <= '0;
      r_lru   <= 1'b0;
      r_drop  <= 1'b0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_hit0) begin
        r_lru <= 1'b1;
      end else if (w_hit1) begin
        r_lru <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (!w_hit) begin
            r_addr  <= {w_tag, 2'b00};
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end else if (PREFETCH_EN && !w_nhit) begin
            r_addr  <= {w_ntag, 2'b00};
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush_i) begin
            r_drop <= 1'b1;
          end
          if (mem_ready_i) begin
            r_cnt   <= r_cnt + 32'd1;
            r_req   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush_i) begin
            r_drop <= 1'b1;
          end
          if (mem_rvalid_i) begin
            if (!r_drop && !flush_i) begin
              if (w_vict) begin
                r_v1    <= 1'b1;
                r_tag1  <= r_addr[31:2];
                r_data1 <= mem_rdata_i;
              end else begin
                r_v0    <= 1'b1;
                r_tag0  <= r_addr[31:2];
                r_data0 <= mem_rdata_i;
              end
            end
            r_drop  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
      // Flush wins over a fill landing on the same edge.
      if (flush_i) begin
        r_v0 <= 1'b0;
        r_v1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: directed bench for ifetch_buffer with a
// single-cycle memory responder and manual response injection.
module tb_ifetch_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] fetch_count_o;

  logic        auto_rsp = 1'b1;
  logic        man_rvalid = 1'b0;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;
  logic        acc_q = 1'b0;
  logic [31:0] pa_q = '0;

  int n_cmp = 0;
  int n_err = 0;

  ifetch_buffer #(
    .PREFETCH_EN(1'b1),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .instr_o      (instr_o),
    .instr_valid_o(instr_valid_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .fetch_count_o(fetch_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0040_0000) ? 32'h0050_0093 : ~a;
  endfunction

  // Memory: response one cycle after acceptance.
  always @(posedge clk) begin
    acc_q = mem_req_o && mem_ready_i;
    pa_q  = mem_addr_o;
    #1;
    mem_rvalid_i = (acc_q && auto_rsp) || man_rvalid;
    mem_rdata_i  = ovr_en ? ovr_val : mem_word(pa_q);
  end

  task automatic tick;
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset(input logic [31:0] pc);
    rst = 1'b1;
    flush_i = 1'b0;
    mem_ready_i = 1'b1;
    auto_rsp = 1'b1;
    man_rvalid = 1'b0;
    ovr_en = 1'b0;
    pc_i = pc;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mem_ready_i = 1'b1;
    pc_i = 32'h0040_0000;
    tick();
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_req got %b want 0", mem_req_o);
    end
    n_cmp++;
    if (mem_addr_o !== 32'h0) begin
      n_err++;
      $display("FAIL rst_addr got %h want 0", mem_addr_o);
    end
    n_cmp++;
    if (fetch_count_o !== 32'h0) begin
      n_err++;
      $display("FAIL rst_cnt got %h want 0", fetch_count_o);
    end
    n_cmp++;
    if (instr_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_vld got %b want 0", instr_valid_o);
    end
    n_cmp++;
    if (instr_o !== NOP) begin
      n_err++;
      $display("FAIL rst_instr got %h want %h", instr_o, NOP);
    end
  endtask

  task automatic test_miss_and_prefetch;
    do_reset(32'h0040_0000);
    n_cmp++;
    if (instr_valid_o !== 1'b0 || instr_o !== NOP) begin
      n_err++;
      $display("FAIL miss_t0 got %b/%h want 0/%h",
               instr_valid_o, instr_o, NOP);
    end
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0040_0000) begin
      n_err++;
      $display("FAIL miss_t1 got %b/%h want 1/00400000",
               mem_req_o, mem_addr_o);
    end
    tick();
    n_cmp++;
    if (instr_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL miss_t2 got %b want 0", instr_valid_o);
    end
    tick();
    n_cmp++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h0050_0093) begin
      n_err++;
      $display("FAIL miss_t3 got %b/%h want 1/00500093",
               instr_valid_o, instr_o);
    end
    n_cmp++;
    if (fetch_count_o !== 32'd1) begin
      n_err++;
      $display("FAIL miss_cnt got %0d want 1", fetch_count_o);
    end
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0040_0004) begin
      n_err++;
      $display("FAIL pf_req got %b/%h want 1/00400004",
               mem_req_o, mem_addr_o);
    end
    tick();
    tick();
    n_cmp++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h0050_0093) begin
      n_err++;
      $display("FAIL pf_keep got %b/%h want 1/00500093",
               instr_valid_o, instr_o);
    end
    n_cmp++;
    if (fetch_count_o !== 32'd2) begin
      n_err++;
      $display("FAIL pf_cnt got %0d want 2", fetch_count_o);
    end
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL pf_idle got %b want 0", mem_req_o);
    end
    pc_i = 32'h0040_0004;
    #1;
    n_cmp++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'hFFBF_FFFB) begin
      n_err++;
      $display("FAIL pf_hit got %b/%h want 1/ffbffffb",
               instr_valid_o, instr_o);
    end
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0040_0008) begin
      n_err++;
      $display("FAIL pf_next got %b/%h want 1/00400008",
               mem_req_o, mem_addr_o);
    end
    n_cmp++;
    if (fetch_count_o !== 32'd2) begin
      n_err++;
      $display("FAIL pf_cnt2 got %0d want 2", fetch_count_o);
    end
    tick();
    tick();
  endtask

  task automatic test_stall;
    do_reset(32'h0040_0000);
    mem_ready_i = 1'b0;
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0040_0000) begin
      n_err++;
      $display("FAIL stall_t1 got %b/%h want 1/00400000",
               mem_req_o, mem_addr_o);
    end
    pc_i = 32'h0040_0100;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0040_0000) begin
        n_err++;
        $display("FAIL stall_hold%0d got %b/%h want 1/00400000",
                 i, mem_req_o, mem_addr_o);
      end
    end
    mem_ready_i = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (instr_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL stall_miss got %b want 0", instr_valid_o);
    end
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0040_0100) begin
      n_err++;
      $display("FAIL stall_dem got %b/%h want 1/00400100",
               mem_req_o, mem_addr_o);
    end
    n_cmp++;
    if (fetch_count_o !== 32'd1) begin
      n_err++;
      $display("FAIL stall_cnt got %0d want 1", fetch_count_o);
    end
    pc_i = 32'h0040_0000;
    #1;
    n_cmp++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h0050_0093) begin
      n_err++;
      $display("FAIL stall_fill got %b/%h want 1/00500093",
               instr_valid_o, instr_o);
    end
  endtask

  task automatic test_flush;
    do_reset(32'h0040_0000);
    auto_rsp = 1'b0;
    ovr_en = 1'b1;
    ovr_val = 32'hDEAD_BEEF;
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    man_rvalid = 1'b1;
    tick();
    man_rvalid = 1'b0;
    tick();
    n_cmp++;
    if (instr_valid_o !== 1'b0 || instr_o !== NOP) begin
      n_err++;
      $display("FAIL flush_drop got %b/%h want 0/%h",
               instr_valid_o, instr_o, NOP);
    end
    n_cmp++;
    if (mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle got %b want 0", mem_req_o);
    end
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0040_0000) begin
      n_err++;
      $display("FAIL flush_req got %b/%h want 1/00400000",
               mem_req_o, mem_addr_o);
    end
    n_cmp++;
    if (fetch_count_o !== 32'd1) begin
      n_err++;
      $display("FAIL flush_cnt got %0d want 1", fetch_count_o);
    end
    ovr_en = 1'b0;
    auto_rsp = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h0050_0093) begin
      n_err++;
      $display("FAIL flush_refill got %b/%h want 1/00500093",
               instr_valid_o, instr_o);
    end
  endtask

  task automatic test_reset_mid;
    do_reset(32'h0040_0000);
    auto_rsp = 1'b0;
    ovr_en = 1'b1;
    ovr_val = 32'h1111_1111;
    tick();
    tick();
    rst = 1'b1;
    man_rvalid = 1'b1;
    tick();
    rst = 1'b0;
    man_rvalid = 1'b0;
    n_cmp++;
    if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      n_err++;
      $display("FAIL rmid_req got %b/%h want 0/0",
               mem_req_o, mem_addr_o);
    end
    n_cmp++;
    if (fetch_count_o !== 32'h0) begin
      n_err++;
      $display("FAIL rmid_cnt got %0d want 0", fetch_count_o);
    end
    n_cmp++;
    if (instr_valid_o !== 1'b0 || instr_o !== NOP) begin
      n_err++;
      $display("FAIL rmid_out got %b/%h want 0/%h",
               instr_valid_o, instr_o, NOP);
    end
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0040_0000) begin
      n_err++;
      $display("FAIL rmid_new got %b/%h want 1/00400000",
               mem_req_o, mem_addr_o);
    end
    pc_i = 32'h0;
    #1;
    n_cmp++;
    if (instr_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_nowr got %b want 0", instr_valid_o);
    end
  endtask

  task automatic test_wrap;
    do_reset(32'hFFFF_FFFC);
    tick();
    n_cmp++;
    if (mem_addr_o !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_dem got %h want fffffffc", mem_addr_o);
    end
    tick();
    tick();
    n_cmp++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h0000_0003) begin
      n_err++;
      $display("FAIL wrap_hit got %b/%h want 1/00000003",
               instr_valid_o, instr_o);
    end
    tick();
    n_cmp++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_pf got %b/%h want 1/00000000",
               mem_req_o, mem_addr_o);
    end
    tick();
    tick();
    pc_i = 32'h0;
    #1;
    n_cmp++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL wrap_pfhit got %b/%h want 1/ffffffff",
               instr_valid_o, instr_o);
    end
  endtask

  task automatic test_unaligned;
    do_reset(32'h0040_0002);
    tick();
    n_cmp++;
    if (mem_addr_o !== 32'h0040_0000) begin
      n_err++;
      $display("FAIL unal_addr got %h want 00400000", mem_addr_o);
    end
    tick();
    tick();
    n_cmp++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h0050_0093) begin
      n_err++;
      $display("FAIL unal_hit got %b/%h want 1/00500093",
               instr_valid_o, instr_o);
    end
  endtask

  initial begin
    test_reset();
    test_miss_and_prefetch();
    test_stall();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_unaligned();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
